pic_ctrl_n: RTL and testbench
=============================

// Module: pic_ctrl_n
// PURPOSE
//  Parametrised, single-clock interrupt controller; next generation of the 8259A-style PIC.
//  Latches NUM_IRQ request lines (edge or level), masks and prioritises them (fixed or rotating),
//  raises INT, and answers one NINTA strobe with an 8-bit vector.
//  Programmed over a synchronous register port; supports nested, auto-EOI, specific/non-specific EOI.
//  No cascade: one controller per instance.
// PARAMETERS
//  NUM_IRQ  8  number of request lines, legal 2..16; index 0 has highest priority at reset
// PORTS
//  CLK        in   1        clock; all state changes on rising edge
//  NRST       in   1        reset, synchronous, active-low
//  NCS        in   1        register-port select, active-low
//  NWR        in   1        write strobe, active-low; write happens at edge with NCS=0 & NWR=0
//  A          in   2        register address
//  DIN        in   16       write data
//  DOUT       out  16       read data, combinational from A; unused upper bits read 0
//  IR         in   NUM_IRQ  request lines, synchronous to CLK
//  INT        out  1        registered interrupt request to the CPU
//  NINTA      in   1        acknowledge, active-low; a falling edge = one acknowledge
//  VEC        out  8        vector of the acknowledged request
//  VEC_VALID  out  1        one-cycle pulse: VEC and SPUR are valid
//  SPUR       out  1        acknowledge found no eligible request
// BEHAVIOUR
//  Reset (NRST=0 at edge): IRR=ISR=IMR=0, CFG=0, LOW=NUM_IRQ-1, ir_q=0, ninta_q=1.
//   Outputs after reset: INT=0, VEC=0, VEC_VALID=0, SPUR=0. Reset mid-acknowledge drops it.
//  Registers:
//   A=0 CFG   RW  [0]=LTIM level mode, [1]=AEOI, [2]=ROT rotating, [15:8]=BASE.
//         A write clears IRR, ISR and IMR, and sets LOW=NUM_IRQ-1.
//   A=1 IMR   RW  bits [NUM_IRQ-1:0]; 1 = masked.
//   A=2 CMD   W   [15]=EOI, [14]=specific, [13]=set-priority, [3:0]=level L. Read returns IRR.
//   A=3 ISR   R   Writes are ignored.
//  Request capture:
//   Edge mode: IRR[i] is set at an edge where IR[i]=1 and ir_q[i]=0. ir_q tracks IR every edge.
//     A line already high at reset is treated as an edge.
//   Level mode: IRR[i] is loaded with IR[i] every edge.
//  Priority: LOW is the index of the lowest-priority line.
//   Order, highest first: LOW+1, LOW+2, ... modulo NUM_IRQ.
//  Eligible: IRR&~IMR bit ranked strictly above the highest-ranked ISR bit (fully nested).
//   Any IRR&~IMR bit is eligible when ISR=0.
//  INT: registered; next value = (any eligible). Latency: IR rises at edge k -> IRR at k -> INT=1 after k+1.
//  Acknowledge: taken at edge t when NINTA=0 and ninta_q=1; holding NINTA low acknowledges once.
//   Winner W = highest-ranked eligible bit.
//     ISR[W] is set unless AEOI. IRR[W] is cleared in edge mode only.
//     If AEOI and ROT, LOW=W.
//   VEC=BASE+W (mod 256), SPUR=0, VEC_VALID=1 during cycle t+1 only.
//   No eligible bit: VEC=BASE+NUM_IRQ-1, SPUR=1, VEC_VALID=1, no state change.
//  EOI (CMD write with [15]=1):
//   Non-specific: clears the highest-ranked ISR bit H; if ROT, LOW=H. No effect if ISR=0.
//   Specific: clears ISR[L].
//   [13]=1: LOW=L, independent of EOI.
//   L>=NUM_IRQ: the specific part and the set-priority part are ignored.
//  Simultaneous events:
//   EOI and acknowledge in the same edge: ISR_next=(ISR&~eoi_clr)|ack_set.
//     The winner is computed from the pre-EOI ISR.
//   IRR set and acknowledge clear on the same bit: set wins.
//   CFG write and acknowledge in the same edge: CFG wins; acknowledge is dropped, no VEC_VALID.
//   IMR write takes effect for eligibility from the next edge.
// TESTING
//  Edge mode, IMR=0, BASE=0x40: IR[3] 0->1 -> IRR=0x08, INT=1 two edges later;
//   NINTA pulse -> VEC=0x43 with VEC_VALID one cycle, ISR=0x08, IRR=0, INT=0.
//  Nested: ISR=0x08 in service, raise IR[5] -> INT stays 0; raise IR[1] -> INT=1;
//   acknowledge -> VEC=BASE+1, ISR=0x0A.
//  Rotating: ROT=1, IR[0] and IR[2] pending -> ack VEC=BASE+0, non-specific EOI -> LOW=0;
//   next ack VEC=BASE+2.
//  AEOI+level: LTIM=1, AEOI=1, IR[6] held high -> each NINTA falling edge gives VEC=BASE+6;
//   ISR stays 0; holding NINTA low 5 cycles -> one VEC_VALID.
//  Spurious/mask: IMR=0xFF, IR[4] rises then NINTA -> SPUR=1, VEC=BASE+NUM_IRQ-1, ISR unchanged.
//  Reset/CFG: NRST=0 mid-service -> all outputs 0 next cycle;
//   CFG write with IRR=0x11 -> IRR=ISR=IMR=0, INT=0.
//  NUM_IRQ=16: IR[15] -> VEC=BASE+15; specific EOI L=15 clears ISR[15];
//   EOI with L=15 when NUM_IRQ=8 -> no effect.

Source files
------------

// File: rtl/pic_ctrl_n.sv
// Single-clock programmable interrupt controller: edge/level capture, masking,
// fixed or rotating priority with full nesting, and vectored acknowledge.
module pic_ctrl_n #(
    parameter int NUM_IRQ = 8
) (
    input  logic               CLK,
    input  logic               NRST,
    input  logic               NCS,
    input  logic               NWR,
    input  logic [1:0]         A,
    input  logic [15:0]        DIN,
    output logic [15:0]        DOUT,
    input  logic [NUM_IRQ-1:0] IR,
    output logic               INT,
    input  logic               NINTA,
    output logic [7:0]         VEC,
    output logic               VEC_VALID,
    output logic               SPUR
);

    localparam logic [3:0]         LAST = 4'(NUM_IRQ - 1);
    localparam logic [NUM_IRQ-1:0] ONE  = NUM_IRQ'(1);

    logic [NUM_IRQ-1:0] irr, isr, imr, ir_q;
    logic               ltim, aeoi, rot, ninta_q;
    logic [7:0]         base;
    logic [3:0]         low;

    logic [NUM_IRQ-1:0] cand, sel, win_oh, top_oh;
    logic [3:0]         pos, win;
    logic               isr_seen, win_found;

    // Walk the lines from highest to lowest rank; a request only wins if it is
    // reached before the first in-service line (full nesting).
    always_comb begin
        cand      = irr & ~imr;
        pos       = (low >= LAST) ? 4'd0 : low + 4'd1;
        sel       = ONE << pos;
        isr_seen  = 1'b0;
        win_found = 1'b0;
        win       = 4'd0;
        win_oh    = '0;
        top_oh    = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (!isr_seen && |(isr & sel)) begin
                isr_seen = 1'b1;
                top_oh   = sel;
            end
            if (!isr_seen && !win_found && |(cand & sel)) begin
                win_found = 1'b1;
                win       = pos;
                win_oh    = sel;
            end
            pos = (pos == LAST) ? 4'd0 : pos + 4'd1;
            sel = {sel[NUM_IRQ-2:0], sel[NUM_IRQ-1]};
        end
    end

    logic               wr, cfg_wr, imr_wr, cmd_wr, lvl_ok, ack, ack_win;
    logic [3:0]         lvl, top_idx;
    logic [NUM_IRQ-1:0] eoi_clr, ack_set, ack_clr, irr_next, isr_next;
    logic [3:0]         low_next;
    logic [7:0]         vec_next;
    logic               unused_bits;

    assign wr          = !NCS && !NWR;
    assign cfg_wr      = wr && (A == 2'd0);
    assign imr_wr      = wr && (A == 2'd1);
    assign cmd_wr      = wr && (A == 2'd2);
    assign lvl         = DIN[3:0];
    assign lvl_ok      = (lvl <= LAST);
    assign ack         = !NINTA && ninta_q && !cfg_wr;
    assign ack_win     = ack && win_found;
    assign unused_bits = ^DIN[12:4];

    always_comb begin
        top_idx = 4'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (top_oh[i]) top_idx = 4'(i);
        end
    end

    always_comb begin
        eoi_clr = '0;
        if (cmd_wr && DIN[15]) begin
            if (DIN[14]) begin
                if (lvl_ok) eoi_clr = ONE << lvl;
            end else begin
                eoi_clr = top_oh;
            end
        end
    end

    assign ack_set  = (ack_win && !aeoi) ? win_oh : '0;
    assign ack_clr  = (ack_win && !ltim) ? win_oh : '0;
    assign irr_next = ltim ? IR : ((irr & ~ack_clr) | (IR & ~ir_q));
    assign isr_next = (isr & ~eoi_clr) | ack_set;
    assign vec_next = ack_win ? base + {4'd0, win} : base + {4'd0, LAST};

    // Later assignments take precedence when several rotation sources coincide.
    always_comb begin
        low_next = low;
        if (cmd_wr && DIN[15] && !DIN[14] && isr_seen && rot) low_next = top_idx;
        if (ack_win && aeoi && rot) low_next = win;
        if (cmd_wr && DIN[13] && lvl_ok) low_next = lvl;
        if (cfg_wr) low_next = LAST;
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            irr       <= '0;
            isr       <= '0;
            imr       <= '0;
            ir_q      <= '0;
            ltim      <= 1'b0;
            aeoi      <= 1'b0;
            rot       <= 1'b0;
            base      <= 8'd0;
            low       <= LAST;
            ninta_q   <= 1'b1;
            INT       <= 1'b0;
            VEC       <= 8'd0;
            VEC_VALID <= 1'b0;
            SPUR      <= 1'b0;
        end else begin
            ir_q      <= IR;
            ninta_q   <= NINTA;
            INT       <= win_found;
            VEC_VALID <= ack;
            low       <= low_next;
            if (ack) begin
                VEC  <= vec_next;
                SPUR <= !win_found;
            end
            if (cfg_wr) begin
                ltim <= DIN[0];
                aeoi <= DIN[1];
                rot  <= DIN[2];
                base <= DIN[15:8];
                irr  <= '0;
                isr  <= '0;
                imr  <= '0;
            end else begin
                irr <= irr_next;
                isr <= isr_next;
                if (imr_wr) imr <= DIN[NUM_IRQ-1:0];
            end
        end
    end

    always_comb begin
        case (A)
            2'd0:    DOUT = {base, 5'd0, rot, aeoi, ltim};
            2'd1:    DOUT = 16'(imr);
            2'd2:    DOUT = 16'(irr);
            default: DOUT = 16'(isr);
        endcase
    end

endmodule

// File: tb/tb_pic_ctrl_n.sv
// Bench for pic_ctrl_n: an 8-line and a 16-line instance share stimulus and are
// compared every cycle against a rank-based behavioural model.
module tb_pic_ctrl_n;

    logic        clk = 1'b0;
    logic        nrst, ncs, nwr, ninta;
    logic [1:0]  a;
    logic [15:0] din, ir;
    logic [15:0] dout8, dout16;
    logic        int8, int16, vv8, vv16, sp8, sp16;
    logic [7:0]  vec8, vec16;

    always #5 clk = ~clk;

    pic_ctrl_n #(.NUM_IRQ(8)) u8 (
        .CLK(clk), .NRST(nrst), .NCS(ncs), .NWR(nwr), .A(a), .DIN(din), .DOUT(dout8),
        .IR(ir[7:0]), .INT(int8), .NINTA(ninta), .VEC(vec8), .VEC_VALID(vv8), .SPUR(sp8)
    );

    pic_ctrl_n #(.NUM_IRQ(16)) u16 (
        .CLK(clk), .NRST(nrst), .NCS(ncs), .NWR(nwr), .A(a), .DIN(din), .DOUT(dout16),
        .IR(ir), .INT(int16), .NINTA(ninta), .VEC(vec16), .VEC_VALID(vv16), .SPUR(sp16)
    );

    int nchk = 0;
    int nerr = 0;

    logic [15:0] m_irr[2], m_isr[2], m_imr[2], m_irq[2], m_cfg[2];
    int          m_low[2];
    logic        m_int[2], m_vv[2], m_sp[2];
    logic [7:0]  m_vec[2];
    logic        m_nq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Rank 0 is the highest priority; the line right after LOW is served first.
    function automatic int rank(input int i, input int low, input int n);
        return (i - low - 1 + 2 * n) % n;
    endfunction

    function automatic logic bitof(input logic [15:0] v, input int i);
        return ((v >> i) & 16'd1) != 16'd0;
    endfunction

    task automatic model_edge();
        logic [15:0] mask, cand, nisr, nirr;
        int          n, top, h, win, best, r, lv, nlow;
        logic        wr, cfgw, ack, ltim, aeoi, rot;
        logic [7:0]  base;
        wr = !ncs && !nwr;
        cfgw = wr && (a == 2'd0);
        lv = int'(din[3:0]);
        for (int k = 0; k < 2; k++) begin
            n = (k == 0) ? 8 : 16;
            mask = (k == 0) ? 16'h00FF : 16'hFFFF;
            if (!nrst) begin
                m_irr[k] = 0; m_isr[k] = 0; m_imr[k] = 0; m_irq[k] = 0; m_cfg[k] = 0;
                m_low[k] = n - 1; m_int[k] = 0; m_vv[k] = 0; m_sp[k] = 0; m_vec[k] = 0;
            end else begin
                ltim = m_cfg[k][0]; aeoi = m_cfg[k][1]; rot = m_cfg[k][2]; base = m_cfg[k][15:8];
                cand = m_irr[k] & ~m_imr[k] & mask;
                top = n; h = -1;
                for (int i = 0; i < n; i++) begin
                    r = rank(i, m_low[k], n);
                    if (bitof(m_isr[k], i) && r < top) begin top = r; h = i; end
                end
                win = -1; best = n;
                for (int i = 0; i < n; i++) begin
                    r = rank(i, m_low[k], n);
                    if (bitof(cand, i) && r < top && r < best) begin best = r; win = i; end
                end
                ack = !ninta && m_nq && !cfgw;
                nlow = m_low[k];
                nisr = m_isr[k];
                if (wr && a == 2'd2 && din[15]) begin
                    if (din[14]) begin
                        if (lv < n) nisr = nisr & ~(16'd1 << lv);
                    end else if (h >= 0) begin
                        nisr = nisr & ~(16'd1 << h);
                        if (rot) nlow = h;
                    end
                end
                if (ack && win >= 0) begin
                    if (!aeoi) nisr = nisr | (16'd1 << win);
                    if (aeoi && rot) nlow = win;
                end
                if (wr && a == 2'd2 && din[13] && lv < n) nlow = lv;
                if (ltim) nirr = ir & mask;
                else begin
                    nirr = m_irr[k];
                    if (ack && win >= 0) nirr = nirr & ~(16'd1 << win);
                    nirr = nirr | (ir & ~m_irq[k] & mask);
                end
                m_int[k] = (win >= 0);
                m_vv[k] = ack;
                if (ack) begin
                    m_vec[k] = 8'(int'(base) + ((win >= 0) ? win : n - 1));
                    m_sp[k] = (win < 0);
                end
                if (cfgw) begin
                    m_cfg[k] = din & 16'hFF07;
                    m_irr[k] = 0; m_isr[k] = 0; m_imr[k] = 0; m_low[k] = n - 1;
                end else begin
                    m_irr[k] = nirr; m_isr[k] = nisr; m_low[k] = nlow;
                    if (wr && a == 2'd1) m_imr[k] = din & mask;
                end
                m_irq[k] = ir & mask;
            end
        end
        m_nq = nrst ? ninta : 1'b1;
    endtask

    task automatic compare();
        logic [15:0] exp_dout;
        for (int k = 0; k < 2; k++) begin
            case (a)
                2'd0:    exp_dout = m_cfg[k];
                2'd1:    exp_dout = m_imr[k];
                2'd2:    exp_dout = m_irr[k];
                default: exp_dout = m_isr[k];
            endcase
            chk((k == 0) ? "int8" : "int16", (k == 0) ? int8 : int16, m_int[k]);
            chk((k == 0) ? "vv8" : "vv16", (k == 0) ? vv8 : vv16, m_vv[k]);
            chk((k == 0) ? "dout8" : "dout16", (k == 0) ? dout8 : dout16, exp_dout);
            if (m_vv[k]) begin
                chk((k == 0) ? "vec8" : "vec16", (k == 0) ? vec8 : vec16, m_vec[k]);
                chk((k == 0) ? "spur8" : "spur16", (k == 0) ? sp8 : sp16, m_sp[k]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic wreg(input logic [1:0] adr, input logic [15:0] d);
        ncs = 1'b0; nwr = 1'b0; a = adr; din = d;
        step();
        ncs = 1'b1; nwr = 1'b1;
    endtask

    task automatic ack_pulse();
        ninta = 1'b0;
        step();
        ninta = 1'b1;
    endtask

    int cnt;

    initial begin
        nrst = 1'b0; ncs = 1'b1; nwr = 1'b1; a = 2'd0; din = 16'd0; ir = 16'd0; ninta = 1'b1;
        m_nq = 1'b1;
        step();
        chk("rst_int", int8, 0); chk("rst_vec", vec8, 0); chk("rst_vv", vv8, 0); chk("rst_spur", sp8, 0);
        nrst = 1'b1;

        // Basic edge capture and acknowledge, BASE=0x40
        wreg(2'd0, 16'h4000);
        a = 2'd2; ir = 16'h0008;
        step(); chk("lit_irr", dout8, 16'h0008); chk("lit_int_lat", int8, 0);
        step(); chk("lit_int", int8, 1);
        ack_pulse(); chk("lit_vec43", vec8, 8'h43); chk("lit_vv", vv8, 1);
        a = 2'd3;
        step(); chk("lit_isr", dout8, 16'h0008); chk("lit_vv_off", vv8, 0); chk("lit_int_off", int8, 0);

        // Nesting: lower priority waits, higher priority interrupts
        ir = 16'h0028; step(); step(); chk("lit_nest_lo", int8, 0);
        ir = 16'h002A; step(); step(); chk("lit_nest_hi", int8, 1);
        ack_pulse(); chk("lit_vec41", vec8, 8'h41);
        step(); chk("lit_isr_0a", dout8, 16'h000A);

        // Rotating priority with non-specific EOI
        ir = 16'h0000; wreg(2'd0, 16'h4004);
        ir = 16'h0005; step(); step();
        ack_pulse(); chk("lit_rot0", vec8, 8'h40);
        step(); wreg(2'd2, 16'h8000); step(); step();
        ack_pulse(); chk("lit_rot2", vec8, 8'h42);
        step(); wreg(2'd2, 16'h8000);

        // Level + AEOI, long acknowledge counts once
        ir = 16'h0000; wreg(2'd0, 16'h4003);
        ir = 16'h0040; step(); step();
        ninta = 1'b0; cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (vv8) cnt++;
            if (i == 0) chk("lit_vec46", vec8, 8'h46);
        end
        chk("lit_one_ack", cnt, 1);
        ninta = 1'b1; a = 2'd3; step(); chk("lit_aeoi_isr", dout8, 16'h0000);
        ack_pulse(); chk("lit_vec46b", vec8, 8'h46);

        // Spurious acknowledge with everything masked
        ir = 16'h0000; wreg(2'd0, 16'h4000); wreg(2'd1, 16'h00FF);
        ir = 16'h0010; step(); step(); chk("lit_mask_int", int8, 0);
        ack_pulse(); chk("lit_spur", sp8, 1); chk("lit_spur_vec", vec8, 8'h47);
        a = 2'd3; step(); chk("lit_spur_isr", dout8, 16'h0000);

        // Reset mid-service
        wreg(2'd1, 16'h0000); step(); step(); ack_pulse();
        nrst = 1'b0; step();
        chk("lit_rst_int", int8, 0); chk("lit_rst_vv", vv8, 0); chk("lit_rst_vec", vec8, 0);
        nrst = 1'b1;

        // CFG write clears pending state
        ir = 16'h0000; wreg(2'd0, 16'h4000);
        a = 2'd2; ir = 16'h0011; step(); chk("lit_irr11", dout8, 16'h0011);
        wreg(2'd0, 16'h4000); a = 2'd2; step();
        chk("lit_cfg_irr", dout8, 16'h0000); chk("lit_cfg_int", int8, 0);

        // 16-line instance: top line and specific EOI on level 15
        ir = 16'h0000; wreg(2'd0, 16'h4000);
        ir = 16'h8000; step(); step();
        ack_pulse(); chk("lit_vec4f", vec16, 8'h4F);
        ir = 16'h8004; step(); step();
        ack_pulse(); chk("lit_vec42_8", vec8, 8'h42); chk("lit_vec42_16", vec16, 8'h42);
        step(); wreg(2'd2, 16'hC00F); a = 2'd3; step();
        chk("lit_eoi15_16", dout16, 16'h0004); chk("lit_eoi15_8", dout8, 16'h0004);

        // Randomized traffic
        nrst = 1'b0; step(); nrst = 1'b1; ir = 16'h0000;
        for (int i = 0; i < 6000; i++) begin
            nrst = ($urandom_range(0, 799) != 0);
            ncs = 1'b1; nwr = 1'b1;
            a = 2'($urandom_range(0, 3));
            din = 16'($urandom);
            if ($urandom_range(0, 11) == 0) begin
                ncs = 1'b0; nwr = 1'($urandom_range(0, 5) == 0);
                if (a == 2'd0 && $urandom_range(0, 7) != 0) a = 2'd2;
                if (a == 2'd2) din = din & 16'hE00F;
                if (a == 2'd0) din = din & 16'hFF07;
            end
            ir = ir ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            ninta = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
